// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the BRAM boot loader:
//   - default BRAM word/address widths and the default boot delay
//   - loader_state_t : FSM state encoding used by bram_loader
//   - is_busy()      : the states in which a load is in progress
// ---------------------------------------------------------------------------
package bram_pkg;

  localparam int BRAM_DATA_W     = 16;
  localparam int BRAM_ADDR_W     = 8;
  localparam int BRAM_BOOT_DELAY = 48;

  // ST_CHECK is only entered when readback verification is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_BOOT  = 3'd4
  } loader_state_t;

  function automatic logic is_busy(input loader_state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/delay_counter.sv
// ---------------------------------------------------------------------------
// delay_counter
// Up-counter that flags when TERMINAL cycles have been counted since the
// last load. The count saturates on the terminal value, so tc stays high
// for as long as enable remains asserted. TERMINAL = 0 disables tc.
//   clk    : clock, posedge
//   rst_n  : asynchronous active-low reset
//   load   : synchronous clear of the count (has priority over enable)
//   enable : count one cycle
//   tc     : terminal count reached (count == TERMINAL-1)
// ---------------------------------------------------------------------------
module delay_counter #(
  parameter int TERMINAL = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam bit HAS_TC = (TERMINAL > 0);
  localparam logic [CW-1:0] LAST = CW'((TERMINAL > 0) ? TERMINAL - 1 : 0);

  logic [CW-1:0] count;

  // Counting stops at the terminal value so the counter never wraps
  // while the owner sits waiting with enable held high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = HAS_TC && (count == LAST);

endmodule

// File: rtl/bram_loader.sv
// ---------------------------------------------------------------------------
// bram_loader
// Streams words from a valid/ready source into a BRAM write port starting
// at base_addr, then after BOOT_DELAY idle cycles raises boot_req to fire
// the warmboot BOOT pin.
//
// Optional feature: define BRAM_LOADER_VERIFY_EN to read back every written
// word (LOAD -> CHECK per word); a mismatch sets a sticky error that blocks
// boot_req. Without the macro rd_en/rd_addr are tied low and error is 0.
//
// Ports:
//   clk, rst_n          : clock (posedge), asynchronous active-low reset
//   start               : begin a load (accepted in IDLE and HOLD)
//   base_addr, length   : first write address, number of words (0..2^ADDR_W)
//   in_valid/in_data/in_ready : input word stream
//   wr_en/wr_addr/data_in     : BRAM write port (data passes through)
//   rd_en/rd_addr/data_out    : BRAM read port, 1-cycle registered read
//   busy, done, error, boot_req : status
// ---------------------------------------------------------------------------
module bram_loader
  import bram_pkg::*;
#(
  parameter int DATA_W     = BRAM_DATA_W,
  parameter int ADDR_W     = BRAM_ADDR_W,
  parameter int BOOT_DELAY = BRAM_BOOT_DELAY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              boot_req
);

  loader_state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;
  logic              done_q;
  logic              start_accept;
  logic              write_fire;
  logic              zero_len;
  logic              boot_tc;
  logic              boot_block;

  assign start_accept = start && ((state == ST_IDLE) || (state == ST_HOLD));
  assign write_fire   = (state == ST_LOAD) && in_valid;
  assign zero_len     = (length == '0);

`ifdef BRAM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] check_addr;
  logic [DATA_W-1:0] expect_data;
  logic              pending;
  logic              error_q;

  // A compare still in flight must also hold off boot, otherwise a very
  // short BOOT_DELAY could boot before the last word's error lands.
  assign boot_block = error_q || pending;
  assign error      = error_q;
`else
  logic last_word;
  logic unused_data_out;

  assign last_word       = (remaining == {{ADDR_W{1'b0}}, 1'b1});
  assign boot_block      = 1'b0;
  assign error           = 1'b0;
  assign unused_data_out = ^data_out;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero-length load skips LOAD entirely; a start in
  // HOLD abandons the pending boot and begins a fresh load.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = zero_len ? ST_HOLD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
`ifdef BRAM_LOADER_VERIFY_EN
          state_next = ST_CHECK;
`else
          state_next = last_word ? ST_HOLD : ST_LOAD;
`endif
        end
      end
`ifdef BRAM_LOADER_VERIFY_EN
      ST_CHECK: begin
        state_next = (remaining == '0) ? ST_HOLD : ST_LOAD;
      end
`endif
      ST_HOLD: begin
        if (start) begin
          state_next = zero_len ? ST_HOLD : ST_LOAD;
        end else if (boot_tc && !boot_block) begin
          state_next = ST_BOOT;
        end
      end
      ST_BOOT: begin
        state_next = ST_BOOT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic. The write port is a zero-latency pass-through of the
  // input stream while in LOAD and is driven to zero everywhere else.
  always_comb begin
    in_ready = (state == ST_LOAD);
    wr_en    = write_fire;
    wr_addr  = (state == ST_LOAD) ? addr_q : '0;
    data_in  = (state == ST_LOAD) ? in_data : '0;
    busy     = is_busy(state);
    boot_req = (state == ST_BOOT);
    done     = done_q;
`ifdef BRAM_LOADER_VERIFY_EN
    rd_en    = (state == ST_CHECK);
    rd_addr  = (state == ST_CHECK) ? check_addr : '0;
`else
    rd_en    = 1'b0;
    rd_addr  = '0;
`endif
  end

  // Load address/count bookkeeping and the done flag. The address wraps
  // naturally at ADDR_W bits; the count is one bit wider so a full
  // 2^ADDR_W-word load can be expressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else if (start_accept) begin
      addr_q    <= base_addr;
      remaining <= length;
      done_q    <= zero_len;
    end else begin
      if (write_fire) begin
        addr_q    <= addr_q + 1'b1;
        remaining <= remaining - 1'b1;
      end
`ifdef BRAM_LOADER_VERIFY_EN
      if ((state == ST_CHECK) && (remaining == '0)) begin
        done_q <= 1'b1;
      end
`else
      if (write_fire && last_word) begin
        done_q <= 1'b1;
      end
`endif
    end
  end

`ifdef BRAM_LOADER_VERIFY_EN
  // Readback: the word and address are captured at write time, the read
  // is issued in CHECK, and data_out is compared on the following cycle
  // (which overlaps the next LOAD cycle or the first HOLD cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_addr  <= '0;
      expect_data <= '0;
      pending     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      pending <= (state == ST_CHECK);
      if (write_fire) begin
        check_addr  <= addr_q;
        expect_data <= in_data;
      end
      if (start_accept) begin
        error_q <= 1'b0;
        pending <= 1'b0;
      end else if (pending && (data_out != expect_data)) begin
        error_q <= 1'b1;
      end
    end
  end
`endif

  // Boot delay: held cleared outside HOLD and on a restarting start, so
  // every HOLD visit counts from zero.
  delay_counter #(
    .TERMINAL (BOOT_DELAY)
  ) u_delay_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   ((state != ST_HOLD) || start),
    .enable (state == ST_HOLD),
    .tc     (boot_tc)
  );

endmodule
